// File: rtl/div_32bit_seq.sv
// Sequential radix-2 non-restoring divider: quotient to LO, remainder to HI, one step per clock.
// Optional macro DIV_ZERO_FAST_EN short-circuits a zero divisor to a 2-edge result.
module div_32bit_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH-1);

    function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    state_t             state_r, state_next_s;
    logic [WIDTH:0]     p_r;
    logic [WIDTH-1:0]   q_r, d_r, a_raw_r;
    logic [CNT_W-1:0]   count_r;
    logic               q_neg_r, r_neg_r, dz_r;

    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_abs_s, b_abs_s;
    logic [WIDTH:0]     p_sh_s, d_ext_s, p_step_s, p_fix_s;
    logic               last_s, load_s, calc_s, fix_s;

    // Operand sign/magnitude and one non-restoring step of the partial remainder.
    always_comb begin
        a_neg_s = is_signed & dividend[WIDTH-1];
        b_neg_s = is_signed & divisor[WIDTH-1];
        if (a_neg_s) a_abs_s = neg2(dividend);
        else         a_abs_s = dividend;
        if (b_neg_s) b_abs_s = neg2(divisor);
        else         b_abs_s = divisor;
        p_sh_s  = {p_r[WIDTH-1:0], q_r[WIDTH-1]};
        d_ext_s = {1'b0, d_r};
        // A negative P is repaired by adding D on the next step instead of restoring now.
        if (p_r[WIDTH]) begin
            p_step_s = p_sh_s + d_ext_s;
            p_fix_s  = p_r + d_ext_s;
        end else begin
            p_step_s = p_sh_s - d_ext_s;
            p_fix_s  = p_r;
        end
        last_s = (count_r == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_r <= S_IDLE;
        else         state_r <= state_next_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: if (start)  state_next_s = S_CALC; else state_next_s = S_IDLE;
            S_CALC: if (last_s) state_next_s = S_FIX;  else state_next_s = S_CALC;
            S_FIX:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Datapath strobes decoded from the state.
    always_comb begin
        load_s = 1'b0;
        calc_s = 1'b0;
        fix_s  = 1'b0;
        case (state_r)
            S_IDLE:  load_s = start;
            S_CALC:  calc_s = 1'b1;
            S_FIX:   fix_s  = 1'b1;
            default: load_s = 1'b0;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            p_r       <= {(WIDTH+1){1'b0}};
            q_r       <= ZERO_W;
            d_r       <= ZERO_W;
            a_raw_r   <= ZERO_W;
            count_r   <= CNT_ZERO;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            dz_r      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= ZERO_W;
            remainder <= ZERO_W;
            div_zero  <= 1'b0;
        end else if (load_s) begin
            p_r      <= {(WIDTH+1){1'b0}};
            q_r      <= a_abs_s;
            d_r      <= b_abs_s;
            a_raw_r  <= dividend;
            q_neg_r  <= a_neg_s ^ b_neg_s;
            r_neg_r  <= a_neg_s;
            dz_r     <= (divisor == ZERO_W);
`ifdef DIV_ZERO_FAST_EN
            // A zero divisor runs only the final step so the forced result lands 2 edges out.
            if (divisor == ZERO_W) count_r <= CNT_LAST;
            else                   count_r <= CNT_ZERO;
`else
            count_r  <= CNT_ZERO;
`endif
            busy     <= 1'b1;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else if (calc_s) begin
            p_r     <= p_step_s;
            q_r     <= {q_r[WIDTH-2:0], ~p_step_s[WIDTH]};
            count_r <= count_r + CNT_ONE;
            done    <= 1'b0;
        end else if (fix_s) begin
            busy <= 1'b0;
            done <= 1'b1;
            if (dz_r) begin
                quotient  <= ONES_W;
                remainder <= a_raw_r;
                div_zero  <= 1'b1;
            end else begin
                quotient  <= q_neg_r ? neg2(q_r) : q_r;
                remainder <= r_neg_r ? neg2(p_fix_s[WIDTH-1:0]) : p_fix_s[WIDTH-1:0];
                div_zero  <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_32bit_seq.sv
// Self-checking bench for div_32bit_seq: directed corner cases plus random operands against a
// plain-arithmetic reference (64-bit integer divide/modulo).
module tb_div_32bit_seq;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy, done, div_zero;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    div_32bit_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .resetn(resetn), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else begin
            q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0;
        end
    endtask

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'd0) ? 2 : 33;
`else
        return 33;
`endif
    endfunction

    // Drive a one-cycle start; returns just after the capture edge.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        if (!done) @(negedge clock);
        is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input logic sgn, input logic [31:0] a,
                             input logic [31:0] b, input int lat);
        logic [31:0] eq, er;
        logic        edz;
        model(sgn, a, b, eq, er, edz);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(b)));
        chk({tag, "_quot"}, {32'd0, quotient}, {32'd0, eq});
        chk({tag, "_rem"}, {32'd0, remainder}, {32'd0, er});
        chk({tag, "_dz"}, {63'd0, div_zero}, {63'd0, edz});
        chk({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b);
        int lat;
        start_op(sgn, a, b);
        wait_done(0, lat);
        check_res(tag, sgn, a, b, lat);
        @(posedge clock); #1;
        chk({tag, "_done_width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int lat;
        logic sgn;
        logic [31:0] a, b;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_quot", {32'd0, quotient}, 64'd0);
        chk("reset_rem", {32'd0, remainder}, 64'd0);
        chk("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clock); resetn = 1'b1;
        @(posedge clock); #1;
        chk("idle_flags", {61'd0, busy, done, div_zero}, 64'd0);

        run_op("u100_7", 1'b0, 32'd100, 32'd7);
        run_op("sm100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
        run_op("s100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9);
        run_op("umax_2", 1'b0, 32'hFFFF_FFFF, 32'd2);
        run_op("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("u7_0", 1'b0, 32'd7, 32'd0);
        run_op("sm7_0", 1'b1, 32'hFFFF_FFF9, 32'd0);
        run_op("umax_umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("u5_9", 1'b0, 32'd5, 32'd9);

        // Start during an operation must be ignored.
        start_op(1'b0, 32'd100, 32'd7);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 10) begin
                is_signed = 1'b1; dividend = 32'd55; divisor = 32'd3; start = 1'b1;
            end
            @(posedge clock); #1;
            start = 1'b0;
        end
        wait_done(10, lat);
        check_res("ignore", 1'b0, 32'd100, 32'd7, lat);

        // Back-to-back start on the done cycle.
        is_signed = 1'b1; dividend = 32'hFFFF_FC18; divisor = 32'd33; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(0, lat);
        check_res("b2b", 1'b1, 32'hFFFF_FC18, 32'd33, lat);
        @(posedge clock); #1;

        // Reset in the middle of an operation.
        start_op(1'b0, 32'd1000, 32'd7);
        repeat (15) @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        chk("rst_quot", {32'd0, quotient}, 64'd0);
        chk("rst_rem", {32'd0, remainder}, 64'd0);
        chk("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (i == 2) resetn = 1'b1;
            if (done) lat++;
        end
        chk("rst_no_done", 64'(lat), 64'd0);
        run_op("u9_3", 1'b0, 32'd9, 32'd3);

        // Random operands.
        for (int n = 0; n < 24; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'd0 - 32'($urandom_range(1, 20));
                default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            run_op($sformatf("rnd%0d", n), sgn, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
